qr_a_loader: RTL and testbench
==============================

// Module: qr_a_loader
// PURPOSE
//  Upstream feeder for qr_cordic: accepts 8x4 A matrices as a 12-bit valid/ready stream in row-major
//  order, stores them in two ping-pong banks, and serves qr_cordic's rd_A row/col reads in place of ROM A.
//  Sequences qr_cordic's en per matrix (high until valid) and loads matrix N+1 while matrix N computes.
// PARAMETERS
//  OUT_WIDTH  12  element width, signed two's complement
//  A_ROW      8   rows per matrix (row address 3 bits)
//  A_COL      4   cols per matrix (col address 2 bits)
// PORTS
//  clk            in   1          system clock
//  rst            in   1          asynchronous reset, active-low
//  s_valid        in   1          stream element valid
//  s_ready        out  1          loader can accept element
//  s_data         in   OUT_WIDTH  element A[r][c], beat k = 4*r + c
//  s_last         in   1          asserted on beat 31 of a matrix
//  rd_A           in   1          read strobe from qr_cordic
//  rd_A_row_addr  in   3          read row
//  rd_A_col_addr  in   2          read col
//  rd_A_data      out  OUT_WIDTH  read data from active bank
//  en             out  1          qr_cordic enable
//  valid          in   1          qr_cordic done
//  frame_err      out  1          sticky: s_last misplaced
//  mat_done       out  1          1-cycle pulse when a matrix is retired
// BEHAVIOUR
//  Reset (rst=0, async): s_ready=0, en=0, rd_A_data=0, frame_err=0, mat_done=0, wr_bank=0, rd_bank=0,
//   bank_full=2'b00, beat_cnt=0, FSM=IDLE. Bank contents are not cleared. First s_ready=1 is the
//   first posedge after rst deasserts.
//  Storage: 2 banks x 32 words. Address = 4*row + col.
//  Load side: s_ready = ~bank_full[wr_bank] (registered). Beat accepted on posedge with s_valid&s_ready:
//   bank[wr_bank][beat_cnt] <= s_data; beat_cnt++. At beat_cnt==31 accept: bank_full[wr_bank]<=1,
//   wr_bank toggles, beat_cnt<=0. s_valid while s_ready=0 is held off, no data lost.
//  frame_err set (sticky until reset) when accepted s_last != (beat_cnt==31). Count rules, not s_last:
//   a frame always closes on the 32nd beat.
//  Read side: on falling clk edge with rd_A=1, rd_A_data <= bank[rd_bank][4*row+col]; holds otherwise.
//   Data is therefore stable at the next rising edge (drop-in timing for ROM A).
//  Sequencer FSM:
//   IDLE:    en=0. If bank_full[rd_bank] -> RUN (en=1 from next cycle).
//   RUN:     en=1. When valid=1 sampled -> RELEASE.
//   RELEASE: en=0 for exactly 1 cycle; bank_full[rd_bank]<=0, rd_bank toggles, mat_done=1 -> IDLE.
//   Min en-low gap between matrices = 2 cycles (RELEASE + IDLE).
//  Simultaneous: RELEASE clearing a bank and loader closing the other bank in same cycle both take
//   effect. A bank freed in RELEASE shows s_ready=1 one cycle later (registered).
//  Both banks full: s_ready=0 until RELEASE.
//  valid while not in RUN: ignored. rd_A while IDLE: reads rd_bank normally (no side effects).
//  Reset mid-operation (load or RUN): all state returns to reset values; partial frame discarded;
//   en drops asynchronously.
// TESTING
//  1 Reset, stream 32 beats (data=k, last on k=31), stub qr_cordic -> en=1 within 2 cycles of beat 31;
//    rd_A row=7 col=3 returns 31; row=2 col=1 returns 9.
//  2 Stream 3 matrices back-to-back, stub asserts valid 200 cycles after en -> s_ready drops after
//    matrix 2, mat_done pulses 3 times, reads of matrix 2 return matrix-2 data (ping-pong correct).
//  3 s_last on beat 20 -> frame_err=1 and stays 1; frame still closes on beat 32 and en asserts.
//  4 Random s_valid gaps (~50%) with negative data (-2048, 2047) -> stored values bit-exact on readback.
//  5 Assert rst=0 mid-RUN and mid-load (beat 17) -> en=0, s_ready=0 immediately; after release the
//    next 32 beats form a fresh matrix at address 0.
//  6 valid pulsed during IDLE with no full bank -> no state change, en stays 0, mat_done stays 0.

Source files
------------

// File: rtl/qr_a_loader_if.sv
// ============================================================================
// Module   : qr_a_loader_if
// Brief    : Valid/ready element stream carrying A-matrix words into qr_a_loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface qr_a_loader_if #(
  parameter int OUT_WIDTH = 12
);
  logic                 s_valid;
  logic                 s_ready;
  logic [OUT_WIDTH-1:0] s_data;
  logic                 s_last;

  modport master (
    output s_valid,
    output s_data,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  s_last,
    output s_ready
  );
endinterface

`default_nettype wire

// File: rtl/qr_a_loader.sv
// ============================================================================
// Module   : qr_a_loader
// Brief    : Ping-pong A-matrix buffer feeding qr_cordic; streams one matrix in
//            while the other is being read, and sequences qr_cordic's enable.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module qr_a_loader #(
  parameter int OUT_WIDTH = 12,
  parameter int A_ROW     = 8,
  parameter int A_COL     = 4
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  qr_a_loader_if.slave                    s,
  input  wire logic                       rd_A,
  input  wire logic [$clog2(A_ROW)-1:0]   rd_A_row_addr,
  input  wire logic [$clog2(A_COL)-1:0]   rd_A_col_addr,
  output logic      [OUT_WIDTH-1:0]       rd_A_data,
  output logic                            en,
  input  wire logic                       valid,
  output logic                            frame_err,
  output logic                            mat_done
);

  localparam int                c_DEPTH = A_ROW * A_COL;
  localparam int                c_AW    = $clog2(c_DEPTH);
  localparam logic [c_AW-1:0]   c_LAST  = c_AW'(c_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  logic [OUT_WIDTH-1:0] r_mem [2*c_DEPTH];

  state_t               r_state;
  logic                 r_wr_bank;
  logic                 r_rd_bank;
  logic [1:0]           r_bank_full;
  logic [c_AW-1:0]      r_beat_cnt;
  logic                 r_s_ready;
  logic                 r_en;
  logic                 r_mat_done;
  logic                 r_frame_err;
  logic [OUT_WIDTH-1:0] r_rd_data;

  logic                 w_acc;
  logic                 w_close;
  logic [1:0]           w_set;
  logic [1:0]           w_clr;
  logic [1:0]           w_hold;
  logic                 w_wr_bank_nxt;
  logic [c_AW-1:0]      w_rd_addr;

  always_comb begin
    w_acc         = s.s_valid & r_s_ready;
    w_close       = w_acc & (r_beat_cnt == c_LAST);
    w_set         = w_close ? (2'b01 << r_wr_bank) : 2'b00;
    w_clr         = (r_state == S_RELEASE) ? (2'b01 << r_rd_bank) : 2'b00;
    w_hold        = r_bank_full | w_set;
    w_wr_bank_nxt = r_wr_bank ^ w_close;
    w_rd_addr     = c_AW'(rd_A_row_addr) * c_AW'(A_COL) + c_AW'(rd_A_col_addr);
  end

  // Storage is deliberately not reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_mem[{r_wr_bank, r_beat_cnt}] <= s.s_data;
    end
  end

  // Ready ignores a release in the same cycle, so a freed bank opens one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_bank   <= 1'b0;
      r_bank_full <= 2'b00;
      r_beat_cnt  <= '0;
      r_s_ready   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_bank_full <= w_hold & ~w_clr;
      r_wr_bank   <= w_wr_bank_nxt;
      r_s_ready   <= ~w_hold[w_wr_bank_nxt];
      if (w_acc) begin
        r_beat_cnt <= w_close ? '0 : r_beat_cnt + 1'b1;
        if (s.s_last != (r_beat_cnt == c_LAST)) begin
          r_frame_err <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_en       <= 1'b0;
      r_mat_done <= 1'b0;
      r_rd_bank  <= 1'b0;
    end else begin
      r_mat_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_bank_full[r_rd_bank]) begin
            r_state <= S_RUN;
            r_en    <= 1'b1;
          end
        end
        S_RUN: begin
          if (valid) begin
            r_state    <= S_RELEASE;
            r_en       <= 1'b0;
            r_mat_done <= 1'b1;
          end
        end
        S_RELEASE: begin
          r_rd_bank <= ~r_rd_bank;
          r_state   <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_en    <= 1'b0;
        end
      endcase
    end
  end

  // Falling-edge read gives qr_cordic stable data at its next rising edge.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_data <= '0;
    end else if (rd_A) begin
      r_rd_data <= r_mem[{r_rd_bank, w_rd_addr}];
    end
  end

  assign s.s_ready = r_s_ready;
  assign rd_A_data = r_rd_data;
  assign en        = r_en;
  assign frame_err = r_frame_err;
  assign mat_done  = r_mat_done;

endmodule

`default_nettype wire

// File: tb/tb_qr_a_loader.sv
// ============================================================================
// Module   : tb_qr_a_loader
// Brief    : Self-checking bench for qr_a_loader with a stub qr_cordic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_qr_a_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd_A = 1'b0;
  logic [2:0]  row = '0;
  logic [1:0]  col = '0;
  logic [11:0] rd_data;
  logic        en, frame_err, mat_done;
  logic        man_valid = 1'b0;
  logic        stub_valid = 1'b0;
  logic        valid_w;

  int errors = 0;
  int checks = 0;
  int mat_cnt = 0;
  int stub_on = 0;
  int stub_lat = 10;
  int stub_cnt = 0;

  // Reference model: flat FIFO of completed matrices (front 32 words = matrix being served)
  logic [11:0] mq[$];
  logic [11:0] cur [32];
  int          cur_n = 0;

  always #5 clk = ~clk;

  assign valid_w = man_valid | stub_valid;

  qr_a_loader_if #(.OUT_WIDTH(12)) s_if ();

  qr_a_loader #(.OUT_WIDTH(12), .A_ROW(8), .A_COL(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .s             (s_if.slave),
    .rd_A          (rd_A),
    .rd_A_row_addr (row),
    .rd_A_col_addr (col),
    .rd_A_data     (rd_data),
    .en            (en),
    .valid         (valid_w),
    .frame_err     (frame_err),
    .mat_done      (mat_done)
  );

  // Stub qr_cordic: one-cycle done pulse stub_lat cycles after en rises
  always @(negedge clk) begin
    if (!rst || en !== 1'b1 || stub_on == 0) begin
      stub_cnt   = 0;
      stub_valid = 1'b0;
    end else begin
      stub_valid = (stub_cnt == stub_lat);
      stub_cnt++;
    end
  end

  always @(negedge clk) begin
    if (rst && mat_done === 1'b1) begin
      mat_cnt++;
      for (int i = 0; i < 32; i++) begin
        if (mq.size() > 0) void'(mq.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [11:0] d, input logic last);
    int   n;
    logic acc;
    s_if.s_valid = 1'b1;
    s_if.s_data  = d;
    s_if.s_last  = last;
    n = 0;
    acc = 1'b0;
    forever begin
      @(negedge clk);
      acc = s_if.s_ready;
      @(posedge clk);
      #1;
      if (acc === 1'b1) break;
      n++;
      if (n >= 2000) break;
    end
    s_if.s_valid = 1'b0;
    s_if.s_last  = 1'b0;
    checks++;
    if (acc !== 1'b1) begin
      errors++;
      $display("FAIL beat_accept: s_ready=%b after 2000 cycles, required 1", acc);
    end else begin
      cur[cur_n] = d;
      cur_n++;
      if (cur_n == 32) begin
        for (int i = 0; i < 32; i++) mq.push_back(cur[i]);
        cur_n = 0;
      end
    end
  endtask

  task automatic send_mat(input logic [11:0] m [32], input int last_pos, input bit gaps);
    for (int k = 0; k < 32; k++) begin
      if (gaps) repeat ($urandom_range(0, 1)) tick();
      send_beat(m[k], k == last_pos);
    end
  endtask

  task automatic read_chk(input int addr, input string name);
    logic [11:0] exp;
    row  = 3'(addr / 4);
    col  = 2'(addr % 4);
    rd_A = 1'b1;
    @(negedge clk);
    #1;
    exp = (mq.size() > addr) ? mq[addr] : 12'hxxx;
    checks++;
    if (mq.size() <= addr || rd_data !== exp) begin
      errors++;
      $display("FAIL %s: addr=%0d rd_A_data=%0d, required %0d", name, addr, $signed(rd_data), $signed(exp));
    end
    rd_A = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_en(input int budget, input string name);
    int n;
    n = 0;
    while (en !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (en !== 1'b1) begin
      errors++;
      $display("FAIL %s: en=%b after %0d cycles, required 1", name, en, budget);
    end
  endtask

  task automatic wait_done(input int target, input string name);
    int n;
    n = 0;
    while (mat_cnt < target && n < 3000) begin
      tick();
      n++;
    end
    checks++;
    if (mat_cnt != target) begin
      errors++;
      $display("FAIL %s: mat_done count=%0d, required %0d", name, mat_cnt, target);
    end
  endtask

  task automatic test_reset();
    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;
    s_if.s_last  = 1'b0;
    rst = 1'b0;
    repeat (3) tick();
    checks += 5;
    if (s_if.s_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: %b, required 0", s_if.s_ready); end
    if (en !== 1'b0)           begin errors++; $display("FAIL rst_en: %b, required 0", en); end
    if (rd_data !== 12'd0)     begin errors++; $display("FAIL rst_rd_data: %0d, required 0", rd_data); end
    if (frame_err !== 1'b0)    begin errors++; $display("FAIL rst_frame_err: %b, required 0", frame_err); end
    if (mat_done !== 1'b0)     begin errors++; $display("FAIL rst_mat_done: %b, required 0", mat_done); end
    @(negedge clk);
    rst = 1'b1;
    tick();
    checks++;
    if (s_if.s_ready !== 1'b1) begin errors++; $display("FAIL rst_first_ready: %b, required 1", s_if.s_ready); end
  endtask

  task automatic test_basic();
    logic [11:0] m [32];
    int          base;
    base = mat_cnt;
    for (int k = 0; k < 32; k++) m[k] = 12'(k);
    stub_on  = 1;
    stub_lat = 40;
    send_mat(m, 31, 1'b0);
    wait_en(2, "en_latency");
    read_chk(31, "rd_r7c3");
    read_chk(9, "rd_r2c1");
    wait_done(base + 1, "basic_done");
  endtask

  task automatic test_back_to_back();
    logic [11:0] m [32];
    int          base;
    base     = mat_cnt;
    stub_lat = 200;
    for (int j = 0; j < 3; j++) begin
      for (int k = 0; k < 32; k++) m[k] = 12'($urandom);
      send_mat(m, 31, 1'b0);
      if (j == 1) begin
        checks++;
        if (s_if.s_ready !== 1'b0) begin
          errors++;
          $display("FAIL ready_drop: s_ready=%b with both banks full, required 0", s_if.s_ready);
        end
      end
    end
    wait_en(50, "b2b_en_m2");
    for (int i = 0; i < 4; i++) read_chk($urandom_range(0, 31), "b2b_rd_m2");
    read_chk(0, "b2b_rd_m2_a0");
    wait_done(base + 3, "b2b_done_count");
  endtask

  task automatic test_frame_err();
    int base;
    base     = mat_cnt;
    stub_lat = 20;
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_pre: %b, required 0", frame_err); end
    for (int k = 0; k < 32; k++) begin
      send_beat(12'(k + 100), k == 20);
      if (k == 20) begin
        checks++;
        if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_set: %b, required 1", frame_err); end
      end
    end
    wait_en(2, "ferr_en");
    read_chk(21, "ferr_rd_a21");
    wait_done(base + 1, "ferr_done");
    checks++;
    if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_sticky: %b, required 1", frame_err); end
  endtask

  task automatic test_random_data();
    logic [11:0] m [32];
    int          base;
    base     = mat_cnt;
    stub_lat = 120;
    for (int k = 0; k < 32; k++) m[k] = 12'($urandom);
    m[0]  = 12'h800;
    m[1]  = 12'h7FF;
    m[30] = 12'h7FF;
    m[31] = 12'h800;
    send_mat(m, 31, 1'b1);
    wait_en(2, "rand_en");
    for (int a = 0; a < 32; a++) read_chk(a, "rand_rd");
    wait_done(base + 1, "rand_done");
  endtask

  task automatic test_reset_mid();
    logic [11:0] m [32];
    int          base;
    stub_lat = 300;
    for (int k = 0; k < 32; k++) m[k] = 12'($urandom);
    send_mat(m, 31, 1'b0);
    wait_en(2, "mid_en_a");
    for (int k = 0; k < 17; k++) send_beat(12'($urandom), 1'b0);
    #2;
    rst = 1'b0;
    #1;
    mq.delete();
    cur_n = 0;
    checks += 4;
    if (en !== 1'b0)           begin errors++; $display("FAIL mid_rst_en: %b, required 0", en); end
    if (s_if.s_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: %b, required 0", s_if.s_ready); end
    if (frame_err !== 1'b0)    begin errors++; $display("FAIL mid_rst_ferr: %b, required 0", frame_err); end
    if (rd_data !== 12'd0)     begin errors++; $display("FAIL mid_rst_rd: %0d, required 0", rd_data); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (en !== 1'b0) begin errors++; $display("FAIL mid_post_en: %b, required 0", en); end
    base     = mat_cnt;
    stub_lat = 40;
    for (int k = 0; k < 32; k++) m[k] = 12'($urandom);
    send_mat(m, 31, 1'b0);
    wait_en(2, "mid_en_c");
    read_chk(0, "mid_rd_a0");
    read_chk(17, "mid_rd_a17");
    read_chk(31, "mid_rd_a31");
    wait_done(base + 1, "mid_done");
  endtask

  task automatic test_valid_idle();
    logic [11:0] m [32];
    int          base;
    base    = mat_cnt;
    stub_on = 0;
    repeat (2) tick();
    man_valid = 1'b1;
    tick();
    man_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (en !== 1'b0) begin errors++; $display("FAIL idle_valid_en: %b, required 0", en); end
    end
    checks += 2;
    if (mat_cnt != base)       begin errors++; $display("FAIL idle_valid_done: count=%0d, required %0d", mat_cnt, base); end
    if (s_if.s_ready !== 1'b1) begin errors++; $display("FAIL idle_valid_ready: %b, required 1", s_if.s_ready); end
    stub_on  = 1;
    stub_lat = 10;
    for (int k = 0; k < 32; k++) m[k] = 12'($urandom);
    send_mat(m, 31, 1'b0);
    wait_en(2, "idle_next_en");
    read_chk(5, "idle_next_rd");
    wait_done(base + 1, "idle_next_done");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_frame_err();
    test_random_data();
    test_reset_mid();
    test_valid_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
